// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory port, decode redirect, and the
// head entry presented to the IF/ID register.
interface inst_fetch_queue_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        IF_ID_write;
   logic        valid_out;
   logic [31:0] inst_out;
   logic [31:0] pc_plus4_out;

   modport slave (
      output mem_req, mem_addr, valid_out, inst_out, pc_plus4_out,
      input  mem_valid, mem_rdata, redirect, redirect_pc, IF_ID_write
   );

   modport master (
      input  mem_req, mem_addr, valid_out, inst_out, pc_plus4_out,
      output mem_valid, mem_rdata, redirect, redirect_pc, IF_ID_write
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch engine with a single outstanding memory request feeding a
// DEPTH-entry circular queue of {instruction, pc+4} toward decode.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   inst_fetch_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [31:0]        r_fetch_pc;
   logic [31:0]        w_fetch_pc_nxt;
   logic [31:0]        r_req_addr;
   logic [31:0]        w_req_addr_nxt;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic [31:0]        r_inst [DEPTH];
   logic [31:0]        r_pc4  [DEPTH];
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic               w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_pop   = !w_empty && bus.IF_ID_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         r_state    <= w_next_state;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
      end
   end

   // r_req_addr is latched at issue so a redirect during DISCARD leaves the bus address intact
   always_comb begin
      w_next_state   = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req_addr_nxt = r_req_addr;
      w_push         = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.redirect) begin
               w_fetch_pc_nxt = bus.redirect_pc;
            end else if (!w_full) begin
               w_next_state   = REQ;
               w_req_addr_nxt = r_fetch_pc;
            end
         end
         REQ: begin
            if (bus.redirect) begin
               w_fetch_pc_nxt = bus.redirect_pc;
               w_next_state   = bus.mem_valid ? IDLE : DISCARD;
            end else if (bus.mem_valid) begin
               w_push         = 1'b1;
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               w_next_state   = IDLE;
            end
         end
         DISCARD: begin
            if (bus.redirect) begin
               w_fetch_pc_nxt = bus.redirect_pc;
            end
            if (bus.mem_valid) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Redirect flushes the whole queue and wins over any push/pop in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.redirect) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_tail] <= bus.mem_rdata;
         r_pc4[r_tail]  <= r_req_addr + 32'd4;
      end
   end

   assign bus.mem_req      = (r_state == REQ) || (r_state == DISCARD);
   assign bus.mem_addr     = r_req_addr;
   assign bus.valid_out    = !w_empty;
   assign bus.inst_out     = w_empty ? 32'h0 : r_inst[r_head];
   assign bus.pc_plus4_out = w_empty ? 32'h0 : r_pc4[r_head];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue; a queue-based model of the
// fetch stream predicts the head entry and the expected fetch address.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_queue_if bus();

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // reference model: expected queue contents and next sequential fetch address
   logic [31:0] m_inst [$];
   logic [31:0] m_pc4  [$];
   logic [31:0] m_pc;
   bit          m_stale;

   // memory responder state
   bit          last_req;
   logic [31:0] last_addr;
   int          age;
   int          cur_lat;
   int          dflt_lat;
   bit          fixed_rdata;
   bit          spurious_en;
   bit          force_mv;

   // per-tick observations for the test tasks
   bit          t_rise;
   bit          t_held;
   logic [31:0] t_rise_addr;
   logic [31:0] t_rise_exp;
   int          t_rise_qsz;
   logic [31:0] t_addr;
   logic [31:0] t_prev_addr;
   bit          e_v;
   logic [31:0] e_i;
   logic [31:0] e_p;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      if (fixed_rdata) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
   endfunction

   task automatic model_clear();
      m_inst.delete();
      m_pc4.delete();
      m_pc      = RESET_PC;
      m_stale   = 1'b0;
      last_req  = 1'b0;
      last_addr = 32'h0;
      age       = 0;
      cur_lat   = 0;
      e_v       = 1'b0;
      e_i       = 32'h0;
      e_p       = 32'h0;
   endtask

   task automatic drive_idle();
      bus.mem_valid   = 1'b0;
      bus.mem_rdata   = 32'h0;
      bus.IF_ID_write = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      force_mv        = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // one clock: called and returns at a falling edge
   task automatic tick(input bit wr, input bit redir, input logic [31:0] rpc);
      bit          req;
      bit          mv;
      logic [31:0] addr;
      req         = bus.mem_req;
      addr        = bus.mem_addr;
      t_rise      = req && !last_req;
      t_held      = req && last_req;
      t_addr      = addr;
      t_prev_addr = last_addr;
      if (t_rise) begin
         age         = 0;
         cur_lat     = (dflt_lat < 0) ? int'($urandom_range(0, 3)) : dflt_lat;
         t_rise_addr = addr;
         t_rise_exp  = m_pc;
         t_rise_qsz  = m_inst.size();
      end else if (req) begin
         age++;
      end
      mv = req ? (age >= cur_lat) : (force_mv || (spurious_en && $urandom_range(0, 9) == 0));
      bus.mem_valid   = mv;
      bus.mem_rdata   = mv ? rdata_of(addr) : $urandom;
      bus.IF_ID_write = wr;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      force_mv        = 1'b0;
      @(posedge clk);
      if (redir) begin
         m_inst.delete();
         m_pc4.delete();
         m_pc    = rpc;
         m_stale = req && !mv;
      end else begin
         if (wr && m_inst.size() > 0) begin
            void'(m_inst.pop_front());
            void'(m_pc4.pop_front());
         end
         if (req && mv) begin
            if (!m_stale) begin
               m_inst.push_back(rdata_of(m_pc));
               m_pc4.push_back(m_pc + 32'd4);
               m_pc = m_pc + 32'd4;
            end
            m_stale = 1'b0;
         end
      end
      last_req  = req;
      last_addr = addr;
      @(negedge clk);
      e_v = (m_inst.size() != 0);
      e_i = e_v ? m_inst[0] : 32'h0;
      e_p = e_v ? m_pc4[0]  : 32'h0;
   endtask

   task automatic test_reset();
      drive_idle();
      #1 rst = 1'b1;
      #1;
      vectors += 4;
      if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
      if (bus.inst_out !== 32'h0) begin miscompares++; $display("FAIL reset_inst_out: got %h want 00000000", bus.inst_out); end
      if (bus.pc_plus4_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc4: got %h want 00000000", bus.pc_plus4_out); end
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick(1'b0, 1'b0, 32'h0);
      vectors += 2;
      if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
      if (bus.mem_addr !== RESET_PC) begin miscompares++; $display("FAIL first_addr: got %h want %h", bus.mem_addr, RESET_PC); end
   endtask

   task automatic test_sequential();
      logic [31:0] addrs [$];
      logic [31:0] pcs   [$];
      do_reset();
      fixed_rdata = 1'b1;
      spurious_en = 1'b0;
      dflt_lat    = 1;
      for (int i = 0; i < 14; i++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (t_rise) addrs.push_back(t_rise_addr);
         if (bus.valid_out === 1'b1) begin
            pcs.push_back(bus.pc_plus4_out);
            vectors++;
            if (bus.inst_out !== 32'h2008_0005) begin miscompares++; $display("FAIL seq_inst: got %h want 20080005", bus.inst_out); end
         end
         vectors += 3;
         if (bus.valid_out !== e_v) begin miscompares++; $display("FAIL seq_valid: got %b want %b", bus.valid_out, e_v); end
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL seq_head_inst: got %h want %h", bus.inst_out, e_i); end
         if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL seq_head_pc4: got %h want %h", bus.pc_plus4_out, e_p); end
      end
      for (int k = 0; k < 3; k++) begin
         vectors += 2;
         if (k >= addrs.size() || addrs[k] !== 32'(4 * k)) begin
            miscompares++;
            $display("FAIL seq_addr%0d: got %h want %h", k, (k < addrs.size()) ? addrs[k] : 32'hx, 32'(4 * k));
         end
         if (k >= pcs.size() || pcs[k] !== 32'(4 * k + 4)) begin
            miscompares++;
            $display("FAIL seq_pc4_%0d: got %h want %h", k, (k < pcs.size()) ? pcs[k] : 32'hx, 32'(4 * k + 4));
         end
      end
      fixed_rdata = 1'b0;
   endtask

   task automatic test_fill();
      int rises;
      do_reset();
      dflt_lat = 1;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         vectors += 3;
         if (bus.valid_out !== e_v) begin miscompares++; $display("FAIL fill_valid: got %b want %b", bus.valid_out, e_v); end
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL fill_inst: got %h want %h", bus.inst_out, e_i); end
         if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL fill_pc4: got %h want %h", bus.pc_plus4_out, e_p); end
         if (i >= 15) begin
            vectors++;
            if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL fill_req_when_full: got %b want 0", bus.mem_req); end
         end
      end
      vectors++;
      if (m_inst.size() != DEPTH || bus.valid_out !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_level: got valid %b model %0d want 1 and %0d", bus.valid_out, m_inst.size(), DEPTH);
      end
      rises = 0;
      tick(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         if (t_rise) rises++;
         vectors += 2;
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL refill_inst: got %h want %h", bus.inst_out, e_i); end
         if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL refill_pc4: got %h want %h", bus.pc_plus4_out, e_p); end
      end
      vectors++;
      if (rises != 1) begin miscompares++; $display("FAIL refill_requests: got %0d want 1", rises); end
   endtask

   task automatic test_redirect_discard();
      bit found;
      do_reset();
      dflt_lat = 1;
      found    = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         if (t_rise && t_rise_addr === 32'h8) found = 1'b1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL disc_reach8: got none want request 00000008"); end
      cur_lat = 3;
      tick(1'b0, 1'b1, 32'h100);
      for (int i = 0; i < 2; i++) begin
         vectors += 3;
         if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL disc_req_held: got %b want 1", bus.mem_req); end
         if (bus.mem_addr !== 32'h8) begin miscompares++; $display("FAIL disc_addr_held: got %h want 00000008", bus.mem_addr); end
         if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL disc_flushed: got %b want 0", bus.valid_out); end
         tick(1'b0, 1'b0, 32'h0);
      end
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         vectors++;
         if (bus.valid_out !== e_v) begin miscompares++; $display("FAIL disc_valid: got %b want %b", bus.valid_out, e_v); end
         tick(1'b0, 1'b0, 32'h0);
         if (t_rise) begin
            found = 1'b1;
            vectors++;
            if (t_rise_addr !== 32'h100) begin miscompares++; $display("FAIL disc_new_addr: got %h want 00000100", t_rise_addr); end
         end
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL disc_timeout: got no request want 00000100"); end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);
      vectors += 2;
      if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL disc_inst: got %h want %h", bus.inst_out, e_i); end
      if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL disc_pc4: got %h want %h", bus.pc_plus4_out, e_p); end
   endtask

   task automatic test_redirect_same();
      bit found;
      do_reset();
      dflt_lat = 1;
      found    = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         if (t_rise && m_inst.size() == 2) found = 1'b1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL same_setup: got none want third request"); end
      tick(1'b1, 1'b1, 32'h200);
      vectors += 2;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL same_flush: got %b want 0", bus.valid_out); end
      if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL same_idle: got %b want 0", bus.mem_req); end
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         vectors++;
         if (bus.valid_out !== e_v) begin miscompares++; $display("FAIL same_valid: got %b want %b", bus.valid_out, e_v); end
         if (t_rise) begin
            found = 1'b1;
            vectors++;
            if (t_rise_addr !== 32'h200) begin miscompares++; $display("FAIL same_new_addr: got %h want 00000200", t_rise_addr); end
         end
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL same_timeout: got no request want 00000200"); end
   endtask

   task automatic test_reset_midreq();
      bit found;
      do_reset();
      dflt_lat = 1;
      found    = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         if (t_rise && m_inst.size() == 2) found = 1'b1;
      end
      vectors += 2;
      if (!found) begin miscompares++; $display("FAIL midrst_setup: got none want request with 2 queued"); end
      if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL midrst_inreq: got %b want 1", bus.mem_req); end
      #2 rst = 1'b1;
      #1;
      vectors += 3;
      if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req_drop: got %b want 0", bus.mem_req); end
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL midrst_valid_drop: got %b want 0", bus.valid_out); end
      if (bus.inst_out !== 32'h0) begin miscompares++; $display("FAIL midrst_inst: got %h want 00000000", bus.inst_out); end
      drive_idle();
      model_clear();
      @(negedge clk);
      rst      = 1'b0;
      force_mv = 1'b1;
      tick(1'b0, 1'b0, 32'h0);
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL midrst_stray_valid: got %b want 0", bus.valid_out); end
      tick(1'b0, 1'b0, 32'h0);
      vectors++;
      if (!t_rise || t_rise_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL midrst_addr: got rise %b addr %h want 1 and %h", t_rise, t_rise_addr, RESET_PC);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 32'h0);
         vectors += 2;
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL midrst_inst_after: got %h want %h", bus.inst_out, e_i); end
         if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL midrst_pc4_after: got %h want %h", bus.pc_plus4_out, e_p); end
      end
   endtask

   task automatic test_back_to_back();
      int  pops;
      bit  wr;
      do_reset();
      dflt_lat = 0;
      for (int i = 0; i < 40 && m_inst.size() < DEPTH; i++) tick(1'b0, 1'b0, 32'h0);
      vectors++;
      if (bus.valid_out !== 1'b1 || m_inst.size() != DEPTH) begin
         miscompares++;
         $display("FAIL b2b_fill: got valid %b model %0d want 1 and %0d", bus.valid_out, m_inst.size(), DEPTH);
      end
      pops = 0;
      for (int i = 0; i < 200 && pops < 3 * DEPTH; i++) begin
         wr = (pops == 0) ? 1'b1 : bus.mem_req;
         if (wr && bus.valid_out === 1'b1) begin
            vectors++;
            if (bus.pc_plus4_out !== 32'(4 * pops + 4)) begin
               miscompares++;
               $display("FAIL b2b_order%0d: got %h want %h", pops, bus.pc_plus4_out, 32'(4 * pops + 4));
            end
            pops++;
         end
         tick(wr, 1'b0, 32'h0);
         vectors += 2;
         if (bus.valid_out !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", bus.valid_out); end
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL b2b_inst: got %h want %h", bus.inst_out, e_i); end
      end
      vectors++;
      if (pops != 3 * DEPTH) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", pops, 3 * DEPTH); end
   endtask

   task automatic test_random();
      bit          wr;
      bit          redir;
      logic [31:0] rpc;
      int          idle_run;
      do_reset();
      dflt_lat    = -1;
      spurious_en = 1'b1;
      idle_run    = 0;
      for (int i = 0; i < 3000; i++) begin
         wr    = ($urandom_range(0, 9) < 6);
         redir = ($urandom_range(0, 29) == 0);
         rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         tick(wr, redir, rpc);
         vectors += 3;
         if (bus.valid_out !== e_v) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.valid_out, e_v); end
         if (bus.inst_out !== e_i) begin miscompares++; $display("FAIL rnd_inst@%0d: got %h want %h", i, bus.inst_out, e_i); end
         if (bus.pc_plus4_out !== e_p) begin miscompares++; $display("FAIL rnd_pc4@%0d: got %h want %h", i, bus.pc_plus4_out, e_p); end
         if (t_rise) begin
            vectors += 2;
            if (t_rise_addr !== t_rise_exp) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h want %h", i, t_rise_addr, t_rise_exp); end
            if (t_rise_qsz >= DEPTH) begin miscompares++; $display("FAIL rnd_req_full@%0d: got level %0d want below %0d", i, t_rise_qsz, DEPTH); end
         end
         if (t_held) begin
            vectors++;
            if (t_addr !== t_prev_addr) begin miscompares++; $display("FAIL rnd_addr_stable@%0d: got %h want %h", i, t_addr, t_prev_addr); end
         end
         if (!bus.mem_req && !redir && m_inst.size() < DEPTH) idle_run++;
         else idle_run = 0;
         if (idle_run > 2) begin
            vectors++;
            miscompares++;
            $display("FAIL rnd_stall@%0d: got %0d idle cycles want at most 2", i, idle_run);
            idle_run = 0;
         end
      end
      spurious_en = 1'b0;
   endtask

   initial begin
      fixed_rdata = 1'b0;
      spurious_en = 1'b0;
      force_mv    = 1'b0;
      dflt_lat    = 1;
      test_reset();
      test_sequential();
      test_fill();
      test_redirect_discard();
      test_redirect_same();
      test_reset_midreq();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
